irq_ctrl_6502: RTL and testbench

Memory-mapped interrupt controller on the 6502 peripheral bus, directly downstream of the timer and other event-producing peripherals. It captures their single-cycle done pulses as pending bits, masks them, and drives the CPU's active-low IRQ line. It also provides a priority vector register so the ISR can find the source with one read.

---
 rtl/irq_ctrl_6502.sv | 82 ++++++++
 tb/tb_irq_ctrl_6502.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_6502.sv
// Memory-mapped interrupt controller for the 6502 bus: edge-captured pending bits, mask,
// write-1-to-clear ACK and a priority VECTOR register. Optional macro IRQ_CTRL_6502_AUTOACK_EN.
module irq_ctrl_6502 #(
  parameter int unsigned BaseAddress   = 0,
  parameter int unsigned NumSources    = 8,
  parameter int unsigned address_width = 16,
  parameter int unsigned data_width    = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  output logic [data_width-1:0]    data_o,
  input  logic                     rd_wr_i,
  input  logic [NumSources-1:0]    irq_src_i,
  output logic                     irq_n_o
);

  localparam logic [address_width-1:0] AddrStatus = address_width'(BaseAddress);
  localparam logic [address_width-1:0] AddrMask   = address_width'(BaseAddress + 1);
  localparam logic [address_width-1:0] AddrAck    = address_width'(BaseAddress + 2);
  localparam logic [address_width-1:0] AddrVector = address_width'(BaseAddress + 3);

  logic [NumSources-1:0] src_q, pending_q, mask_q;
  logic [NumSources-1:0] rise, masked, ack_clr, auto_clr, pending_d, mask_d;
  logic [data_width-1:0] vector, rd_data;
  logic                  wr_mask, wr_ack;

  assign rise    = irq_src_i & ~src_q;
  assign masked  = pending_q & mask_q;
  assign wr_mask = rd_wr_i && (address_i == AddrMask);
  assign wr_ack  = rd_wr_i && (address_i == AddrAck);
  assign ack_clr = wr_ack ? data_i[NumSources-1:0] : '0;
  assign mask_d  = wr_mask ? data_i[NumSources-1:0] : mask_q;

`ifdef IRQ_CTRL_6502_AUTOACK_EN
  logic rd_vec;
  assign rd_vec   = !rd_wr_i && (address_i == AddrVector);
  // Lowest set bit of masked is exactly the source VECTOR reports.
  assign auto_clr = rd_vec ? (masked & (~masked + NumSources'(1))) : '0;
`else
  assign auto_clr = '0;
`endif

  // A rising edge in the same cycle as a clear keeps the bit set.
  assign pending_d = (pending_q & ~ack_clr & ~auto_clr) | rise;

  always_comb begin
    vector = 8'hFF;
    for (int i = int'(NumSources) - 1; i >= 0; i--) begin
      if (masked[i]) vector = data_width'(i);
    end
  end

  always_comb begin
    rd_data = '0;
    if (address_i == AddrStatus) begin
      rd_data = data_width'(pending_q);
    end else if (address_i == AddrMask) begin
      rd_data = data_width'(mask_q);
    end else if (address_i == AddrVector) begin
      rd_data = vector;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      data_o    <= '0;
      irq_n_o   <= 1'b1;
    end else begin
      src_q     <= irq_src_i;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_n_o   <= ~|masked;
      if (!rd_wr_i) data_o <= rd_data;
    end
  end

endmodule

// File: tb/tb_irq_ctrl_6502.sv
// Self-checking bench for irq_ctrl_6502: per-cycle reference model plus directed literal checks.
module tb_irq_ctrl_6502;

  localparam logic [15:0] AStatus = 16'h0000;
  localparam logic [15:0] AMask   = 16'h0001;
  localparam logic [15:0] AAck    = 16'h0002;
  localparam logic [15:0] AVector = 16'h0003;
  localparam logic [15:0] AIdle   = 16'h0010;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [15:0] address_i = AIdle;
  logic [7:0]  data_i = 8'h00;
  logic [7:0]  data_o;
  logic        rd_wr_i = 1'b0;
  logic [7:0]  irq_src_i = 8'h00;
  logic        irq_n_o;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl_6502 dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .address_i(address_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .rd_wr_i  (rd_wr_i),
    .irq_src_i(irq_src_i),
    .irq_n_o  (irq_n_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: per-source behaviour evaluated from the register-map rules.
  bit [7:0] m_pend, m_mask, m_prev, m_data;
  bit       m_irq_n;

  function automatic bit [7:0] model_read(input logic [15:0] a);
    bit [7:0] r = 8'h00;
    if (a == AStatus) r = m_pend;
    else if (a == AMask) r = m_mask;
    else if (a == AVector) begin
      r = 8'hFF;
      for (int i = 0; i < 8; i++) begin
        if (m_pend[i] && m_mask[i]) begin
          r = 8'(i);
          break;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_data = 0; m_irq_n = 1;
    end else begin
      bit [7:0] vec;
      bit [7:0] np;
      vec     = model_read(AVector);
      m_irq_n = ((m_pend & m_mask) == 8'h00);
      if (!rd_wr_i) m_data = model_read(address_i);
      np = m_pend;
      for (int i = 0; i < 8; i++) begin
        if (irq_src_i[i] && !m_prev[i]) np[i] = 1;
        else if (rd_wr_i && address_i == AAck && data_i[i]) np[i] = 0;
`ifdef IRQ_CTRL_6502_AUTOACK_EN
        else if (!rd_wr_i && address_i == AVector && vec == 8'(i)) np[i] = 0;
`endif
      end
      if (rd_wr_i && address_i == AMask) m_mask = data_i;
      m_pend = np;
      m_prev = irq_src_i;
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (reset_i) begin
      check("model data_o", data_o, m_data);
      check("model irq_n_o", {7'b0, irq_n_o}, {7'b0, m_irq_n});
    end
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_i);
    address_i = a; data_i = d; rd_wr_i = 1'b1;
    @(negedge clk_i);
    address_i = AIdle; rd_wr_i = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
    @(negedge clk_i);
    address_i = a; rd_wr_i = 1'b0;
    @(posedge clk_i);
    #1 check(name, data_o, exp);
  endtask

  task automatic pulse(input logic [7:0] srcs);
    @(negedge clk_i);
    irq_src_i = srcs;
    @(negedge clk_i);
    irq_src_i = 8'h00;
    address_i = AIdle;
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    #1 check("reset data_o", data_o, 8'h00);
    check("reset irq_n_o", {7'b0, irq_n_o}, 8'h01);
    reset_i = 1'b1;
    rd(AMask, 8'h00, "reset mask");

    // Single masked source
    wr(AMask, 8'h01);
    pulse(8'h01);
    check("irq still high 1 edge after pulse", {7'b0, irq_n_o}, 8'h01);
    @(posedge clk_i); #1 check("irq low 2 edges after pulse", {7'b0, irq_n_o}, 8'h00);
    rd(AStatus, 8'h01, "status src0");
    wr(AAck, 8'h01);
    check("irq low right after ack edge", {7'b0, irq_n_o}, 8'h00);
    @(posedge clk_i); #1 check("irq high after ack", {7'b0, irq_n_o}, 8'h01);
    rd(AStatus, 8'h00, "status after ack");

    // Masked sources latch, unmask raises irq
    wr(AMask, 8'h00);
    pulse(8'h24);
    rd(AStatus, 8'h24, "status 2,5");
    check("irq masked", {7'b0, irq_n_o}, 8'h01);
    rd(AVector, 8'hFF, "vector none");
    wr(AMask, 8'h20);
    @(posedge clk_i); #1 check("irq after unmask", {7'b0, irq_n_o}, 8'h00);
    rd(AVector, 8'h05, "vector 5");
    wr(AAck, 8'hFF);
    wr(AMask, 8'h00);

    // Held-high source sets once
    @(negedge clk_i); irq_src_i[3] = 1'b1;
    repeat (4) @(negedge clk_i);
    wr(AAck, 8'h08);
    repeat (3) @(negedge clk_i);
    rd(AStatus, 8'h00, "held src no reset");
    @(negedge clk_i); irq_src_i[3] = 1'b0;
    @(negedge clk_i); irq_src_i[3] = 1'b1;
    @(negedge clk_i); irq_src_i[3] = 1'b0;
    rd(AStatus, 8'h08, "re-raised src3");

    // Set beats ACK in the same cycle
    @(negedge clk_i);
    address_i = AAck; data_i = 8'h02; rd_wr_i = 1'b1; irq_src_i[1] = 1'b1;
    @(negedge clk_i);
    address_i = AIdle; rd_wr_i = 1'b0; irq_src_i[1] = 1'b0;
    rd(AStatus, 8'h0A, "set wins over ack");

    wr(AMask, 8'hFF);
`ifdef IRQ_CTRL_6502_AUTOACK_EN
    rd(AVector, 8'h01, "autoack vec1");
    rd(AStatus, 8'h08, "autoack status1");
    rd(AVector, 8'h03, "autoack vec2");
    rd(AStatus, 8'h00, "autoack status2");
    check("autoack irq high", {7'b0, irq_n_o}, 8'h01);
`else
    rd(AVector, 8'h01, "vec read 1");
    rd(AStatus, 8'h0A, "status after vec 1");
    rd(AVector, 8'h01, "vec read 2");
    rd(AStatus, 8'h0A, "status after vec 2");
    check("irq still low", {7'b0, irq_n_o}, 8'h00);
`endif

    // Asynchronous reset while an interrupt is asserted
    pulse(8'h01);
    @(posedge clk_i); #1 check("irq low before reset", {7'b0, irq_n_o}, 8'h00);
    @(negedge clk_i);
    #2 reset_i = 1'b0;
    #1 check("async reset irq", {7'b0, irq_n_o}, 8'h01);
    check("async reset data", data_o, 8'h00);
    @(negedge clk_i); reset_i = 1'b1;
    rd(AStatus, 8'h00, "status after reset");
    rd(AMask, 8'h00, "mask after reset");

    repeat (2) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
